// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op and state encodings and the default operand width shared by the MDU.
package mult_div_unit_pkg;
    localparam int MDU_WIDTH = 32;
    typedef enum logic [1:0] {
        MDU_OP_MULTU = 2'b00,
        MDU_OP_MULT  = 2'b01,
        MDU_OP_DIVU  = 2'b10,
        MDU_OP_DIV   = 2'b11
    } mdu_op_e;
    typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FIX} mdu_state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = mult_div_unit_pkg::MDU_WIDTH) ();
    logic                       start;
    mult_div_unit_pkg::mdu_op_e op;
    logic [WIDTH-1:0]           src_a;
    logic [WIDTH-1:0]           src_b;
    logic                       busy;
    logic                       done;
    logic [WIDTH-1:0]           hi;
    logic [WIDTH-1:0]           lo;
    modport master (output start, op, src_a, src_b, input busy, done, hi, lo);
    modport slave (input start, op, src_a, src_b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit_iter_core.sv
// mult_div_unit_iter_core: one shift-add multiply or restoring-divide step per cycle on unsigned magnitudes.
module mult_div_unit_iter_core #(parameter int WIDTH = 32) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   init_lo,
    input  logic [WIDTH-1:0]   mag_m,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0]   m;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sh_hi;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] nxt;
    assign last = cnt == CW'(WIDTH - 1);
    // Multiply shifts right with the adder carry; divide shifts left and keeps the trial subtraction when it fits.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        sh_hi = acc[2*WIDTH-1:WIDTH-1];
        diff  = sh_hi[WIDTH-1:0] - m;
        nxt   = !is_div ? {sum, acc[WIDTH-1:1]}
              : (sh_hi >= {1'b0, m}) ? {diff, acc[WIDTH-2:0], 1'b1}
              : {sh_hi[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
            m   <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, init_lo};
            m   <= mag_m;
            cnt <= '0;
        end else if (step) begin
            acc <= nxt;
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO registers.
// Signed MULT/DIV only when MDU_SIGNED_EN is defined; otherwise they run as MULTU/DIVU.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic            CLK,
    input logic            RST,
    mult_div_unit_if.slave bus
);
    mdu_state_e         state, state_n;
    logic               is_div, neg_lo, neg_hi, sa, sb, load, last;
    logic [WIDTH-1:0]   mag_a, mag_b, hi_n, lo_n;
    logic [2*WIDTH-1:0] acc;
`ifdef MDU_SIGNED_EN
    assign sa    = bus.op[0] & bus.src_a[WIDTH-1];
    assign sb    = bus.op[0] & bus.src_b[WIDTH-1];
    assign mag_a = sa ? -bus.src_a : bus.src_a;
    assign mag_b = sb ? -bus.src_b : bus.src_b;
`else
    assign sa    = 1'b0;
    assign sb    = 1'b0;
    assign mag_a = bus.src_a;
    assign mag_b = bus.src_b;
`endif
    assign load     = state == MDU_IDLE && bus.start;
    assign bus.busy = state != MDU_IDLE;
    mult_div_unit_iter_core #(.WIDTH(WIDTH)) core (
        .CLK(CLK), .RST(RST), .load(load), .step(state == MDU_RUN), .is_div(is_div),
        .init_lo(bus.op[1] ? mag_a : mag_b), .mag_m(bus.op[1] ? mag_b : mag_a),
        .acc(acc), .last(last)
    );
    always_ff @(posedge CLK) state <= RST ? MDU_IDLE : state_n;
    always_comb begin
        state_n = state == MDU_IDLE ? (bus.start ? MDU_RUN : MDU_IDLE)
                : state == MDU_RUN  ? (last ? MDU_FIX : MDU_RUN)
                : MDU_IDLE;
    end
    // A zero divisor keeps the all-ones quotient unnegated; the product upper half borrows from the lower half.
    always_comb begin
        lo_n = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        hi_n = !neg_hi ? acc[2*WIDTH-1:WIDTH]
             : is_div ? -acc[2*WIDTH-1:WIDTH]
             : ~acc[2*WIDTH-1:WIDTH] + WIDTH'(acc[WIDTH-1:0] == '0);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (load) begin
            is_div <= bus.op[1];
            neg_lo <= (sa ^ sb) && |bus.src_b;
            neg_hi <= bus.op[1] ? sa : (sa ^ sb);
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= state == MDU_FIX;
            if (state == MDU_FIX) begin
                bus.hi <= hi_n;
                bus.lo <= lo_n;
            end
        end
    end
endmodule
